// File: rtl/dense_row_scheduler_if.sv
// Row/result handshake bundle for the dense front-end scheduler.
// The slave side is the scheduler; the master side is its environment.
interface dense_row_scheduler_if #(
   parameter int W          = 3,
   parameter int D          = 12,
   parameter int B          = 64,
   parameter int DATA_WIDTH = 8
);
   localparam int RW = W * D * DATA_WIDTH;

   logic                    row_valid_i;
   logic                    row_ready_o;
   logic [RW-1:0]           row_data_i;
   logic                    dense_valid_o;
   logic [RW-1:0]           dense_data_o;
   logic                    dense_res_valid_i;
   logic [DATA_WIDTH-1:0]   dense_res_i;
   logic                    res_valid_o;
   logic [B*DATA_WIDTH-1:0] res_data_o;
   logic                    res_ready_i;
   logic                    err_o;

   modport master (
      output row_valid_i, row_data_i, dense_res_valid_i,
      output dense_res_i, res_ready_i,
      input  row_ready_o, dense_valid_o, dense_data_o,
      input  res_valid_o, res_data_o, err_o
   );

   modport slave (
      input  row_valid_i, row_data_i, dense_res_valid_i,
      input  dense_res_i, res_ready_i,
      output row_ready_o, dense_valid_o, dense_data_o,
      output res_valid_o, res_data_o, err_o
   );
endinterface

// File: rtl/dense_row_scheduler.sv
// Dense front-end scheduler: issues H rows to the datapath,
// gathers the B result bytes of the last row into one vector.
module dense_row_scheduler #(
   parameter int H          = 3,
   parameter int W          = 3,
   parameter int D          = 12,
   parameter int B          = 64,
   parameter int DATA_WIDTH = 8,
   parameter int ROW_CYCLES = 2 * B + 2
) (
   input logic                  clk,
   input logic                  rstn,
   dense_row_scheduler_if.slave bus
);
   localparam int RW = W * D * DATA_WIDTH;
   localparam int HW = (H > 1) ? $clog2(H) : 1;
   localparam int IW = $clog2(B + 1);
   localparam int CW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;

   localparam logic [HW-1:0] H_LAST = HW'(H - 1);
   localparam logic [IW-1:0] B_FULL = IW'(B);
   localparam logic [CW-1:0] C_INIT = CW'(ROW_CYCLES - 1);

   typedef enum logic [2:0] {
      S_LOAD,
      S_ISSUE,
      S_WAIT,
      S_COLLECT,
      S_OUT
   } state_t;

   state_t                  state_q, state_d;
   logic [HW-1:0]           h_cnt_q, h_cnt_d;
   logic [CW-1:0]           wait_cnt_q, wait_cnt_d;
   logic [IW-1:0]           res_idx_q, res_idx_d;
   logic [RW-1:0]           row_q, row_d;
   logic [B*DATA_WIDTH-1:0] res_q, res_d;
   logic                    err_q, err_d;
   logic                    cap_win;

   // Next-state, result capture and sticky error evaluation.
   always_comb begin
      state_d    = state_q;
      h_cnt_d    = h_cnt_q;
      wait_cnt_d = wait_cnt_q;
      res_idx_d  = res_idx_q;
      row_d      = row_q;
      res_d      = res_q;
      err_d      = err_q;

      cap_win = (h_cnt_q == H_LAST)
              && (state_q == S_WAIT || state_q == S_COLLECT)
              && (res_idx_q < B_FULL);

      if (bus.dense_res_valid_i) begin
         if (cap_win) begin
            for (int k = 0; k < B; k++) begin
               if (res_idx_q == IW'(k)) begin
                  res_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.dense_res_i;
               end
            end
            res_idx_d = res_idx_q + IW'(1);
         end else begin
            err_d = 1'b1;
         end
      end

      unique case (state_q)
         S_LOAD: begin
            if (bus.row_valid_i) begin
               row_d   = bus.row_data_i;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wait_cnt_d = C_INIT;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt_q == '0) begin
               if (h_cnt_q == H_LAST) begin
                  wait_cnt_d = C_INIT;
                  state_d    = S_COLLECT;
               end else begin
                  h_cnt_d = h_cnt_q + HW'(1);
                  state_d = S_LOAD;
               end
            end else begin
               wait_cnt_d = wait_cnt_q - CW'(1);
            end
         end
         S_COLLECT: begin
            if (res_idx_q == B_FULL) begin
               state_d = S_OUT;
            end else if (wait_cnt_q == '0) begin
               err_d   = 1'b1;
               state_d = S_OUT;
            end else begin
               wait_cnt_d = wait_cnt_q - CW'(1);
            end
         end
         S_OUT: begin
            if (bus.res_ready_i) begin
               h_cnt_d   = '0;
               res_idx_d = '0;
               state_d   = S_LOAD;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_LOAD;
         h_cnt_q    <= '0;
         wait_cnt_q <= '0;
         res_idx_q  <= '0;
         row_q      <= '0;
         res_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         h_cnt_q    <= h_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         res_idx_q  <= res_idx_d;
         row_q      <= row_d;
         res_q      <= res_d;
         err_q      <= err_d;
      end
   end

   assign bus.row_ready_o   = rstn && (state_q == S_LOAD);
   assign bus.dense_valid_o = (state_q == S_ISSUE);
   assign bus.res_valid_o   = (state_q == S_OUT);
   assign bus.dense_data_o  = row_q;
   assign bus.res_data_o    = res_q;
   assign bus.err_o         = err_q;
endmodule

// File: tb/tb_dense_row_scheduler.sv
// Bench for dense_row_scheduler: random rows and result bytes,
// timeline reference model, per-cycle compare plus literal checks.
module tb_dense_row_scheduler;
   localparam int H  = 3;
   localparam int W  = 3;
   localparam int D  = 12;
   localparam int B  = 4;
   localparam int DW = 8;
   localparam int RC = 2 * B + 2;
   localparam int RW = W * D * DW;

   logic clk;
   logic rstn;
   int   cyc;
   int   total;
   int   bad;

   dense_row_scheduler_if #(
      .W(W), .D(D), .B(B), .DATA_WIDTH(DW)
   ) bus ();

   dense_row_scheduler #(
      .H(H), .W(W), .D(D), .B(B),
      .DATA_WIDTH(DW), .ROW_CYCLES(RC)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus.slave)
   );

   // reference model state
   int          m_rows  = 0;
   int          m_since = 1000;
   int          m_cnt   = 0;
   bit          m_out   = 0;
   bit          m_err   = 0;
   logic [RW-1:0] m_row = '0;
   logic [7:0]  m_res [B];

   // datapath emitter controls
   logic [7:0]  res_bytes [B];
   int          emit_n;
   bit          spur_en;
   int          pulse_t [$];

   task automatic chk(input string nm, input logic [511:0] act,
                      input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] rand_row();
      logic [RW-1:0] r;
      r = '0;
      for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [B*DW-1:0] pack_bytes(input int n);
      logic [B*DW-1:0] e;
      e = '0;
      for (int k = 0; k < B; k++)
         if (k < n) e[k*DW +: DW] = res_bytes[k];
      return e;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Reference model: rows counted per frame, cycles since last
   // accepted row, bytes captured; all timing derived from those.
   initial begin
      bit rdy, hs, so, cap;
      foreach (m_res[i]) m_res[i] = 8'h00;
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) begin
            m_rows = 0; m_since = 1000; m_cnt = 0;
            m_out = 0; m_err = 0; m_row = '0;
            foreach (m_res[i]) m_res[i] = 8'h00;
         end else begin
            rdy = m_rows < H && m_since >= RC + 2 && !m_out;
            hs  = m_out && bus.res_ready_i;
            so  = m_rows == H && !m_out && m_since >= RC + 2
               && (m_cnt == B || m_since >= 2 * RC + 1);
            cap = bus.dense_res_valid_i && m_rows == H
               && m_since >= 2 && !m_out && m_cnt < B;
            if (bus.dense_res_valid_i && !cap) m_err = 1;
            if (cap) begin
               m_res[m_cnt] = bus.dense_res_i;
               m_cnt++;
            end
            if (so && m_cnt != B) m_err = 1;
            if (m_since < 1000) m_since++;
            if (rdy && bus.row_valid_i) begin
               m_row = bus.row_data_i;
               m_rows++;
               m_since = 1;
            end
            if (so) m_out = 1;
            if (hs) begin
               m_out = 0; m_rows = 0; m_cnt = 0; m_since = 1000;
            end
         end
      end
   end

   // Per-cycle compare of every output against the model.
   initial begin
      logic [B*DW-1:0] e;
      forever begin
         @(negedge clk);
         e = '0;
         for (int k = 0; k < B; k++) e[k*DW +: DW] = m_res[k];
         chk("row_ready", 512'(bus.row_ready_o),
             512'(rstn && m_rows < H && m_since >= RC + 2 && !m_out));
         chk("dense_valid", 512'(bus.dense_valid_o), 512'(m_since == 1));
         chk("dense_data", 512'(bus.dense_data_o), 512'(m_row));
         chk("res_valid", 512'(bus.res_valid_o), 512'(m_out));
         chk("res_data", 512'(bus.res_data_o), 512'(e));
         chk("err", 512'(bus.err_o), 512'(m_err));
         if (bus.dense_valid_o) pulse_t.push_back(cyc);
      end
   end

   // Datapath stand-in: results during the last row of each frame,
   // optional stray strobe while the first row is issued.
   initial begin
      int p, left, gap, k;
      p = 0; left = 0; gap = 0; k = 0;
      bus.dense_res_valid_i = 1'b0;
      bus.dense_res_i = 8'h00;
      forever begin
         @(negedge clk);
         bus.dense_res_valid_i = 1'b0;
         if (!rstn) begin
            p = 0; left = 0;
         end else begin
            if (left > 0) begin
               if (gap == 0) begin
                  bus.dense_res_valid_i = 1'b1;
                  bus.dense_res_i = res_bytes[k];
                  k++; left--;
                  gap = $urandom_range(0, 1);
               end else begin
                  gap--;
               end
            end
            if (bus.dense_valid_o) begin
               p++;
               if (p % H == 0) begin
                  left = emit_n; k = 0; gap = 0;
               end else if (p % H == 1 && spur_en) begin
                  bus.dense_res_valid_i = 1'b1;
                  bus.dense_res_i = 8'h7F;
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic send_row(input logic [RW-1:0] d);
      int n;
      n = 0;
      bus.row_valid_i = 1'b1;
      bus.row_data_i  = d;
      while (!bus.row_ready_o && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         total++; bad++;
         $display("FAIL row_accept got=timeout want=accept");
      end
      @(negedge clk);
      bus.row_valid_i = 1'b0;
   endtask

   task automatic send_frame();
      for (int r = 0; r < H; r++) send_row(rand_row());
   endtask

   task automatic wait_out(output int t);
      int n;
      n = 0;
      while (!bus.res_valid_o && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         total++; bad++;
         $display("FAIL res_valid got=timeout want=valid");
      end
      t = cyc;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rstn = 1'b0;
      repeat (2) @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic rand_bytes();
      for (int k = 0; k < B; k++) res_bytes[k] = 8'($urandom);
   endtask

   initial begin
      int t, n0, hs;
      total = 0; bad = 0;
      rstn = 1'b0;
      bus.row_valid_i = 1'b0;
      bus.row_data_i  = '0;
      bus.res_ready_i = 1'b1;
      emit_n = B; spur_en = 0;
      res_bytes[0] = 8'h11; res_bytes[1] = 8'h22;
      res_bytes[2] = 8'h33; res_bytes[3] = 8'h44;
      repeat (2) @(negedge clk);
      chk("rst_ready", 512'(bus.row_ready_o), 512'(0));
      chk("rst_err", 512'(bus.err_o), 512'(0));
      @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 512'(bus.row_ready_o), 512'(1));

      // basic frame
      n0 = pulse_t.size();
      send_frame();
      wait_out(t);
      chk("t1_res", 512'(bus.res_data_o), 512'(32'h44332211));
      chk("t1_err", 512'(bus.err_o), 512'(0));
      chk("t1_pulses", 512'(pulse_t.size() - n0), 512'(3));
      chk("t1_gap0", 512'(pulse_t[n0+1] - pulse_t[n0]), 512'(12));
      chk("t1_gap1", 512'(pulse_t[n0+2] - pulse_t[n0+1]), 512'(12));
      chk("t1_lat", 512'(t - pulse_t[n0+2]), 512'(RC + 2));
      @(negedge clk);

      // result stall
      rand_bytes();
      bus.res_ready_i = 1'b0;
      send_frame();
      wait_out(t);
      bus.row_valid_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.row_data_i = rand_row();
         chk("t2_hold", 512'(bus.res_data_o), 512'(pack_bytes(B)));
         chk("t2_noready", 512'(bus.row_ready_o), 512'(0));
         @(negedge clk);
      end
      bus.res_ready_i = 1'b1;
      @(negedge clk);
      chk("t2_ready", 512'(bus.row_ready_o), 512'(1));
      bus.row_valid_i = 1'b0;
      @(negedge clk);

      // missing result byte
      do_reset();
      res_bytes[0] = 8'h11; res_bytes[1] = 8'h22;
      res_bytes[2] = 8'h33; res_bytes[3] = 8'h44;
      emit_n = 3;
      send_frame();
      wait_out(t);
      chk("t3_res", 512'(bus.res_data_o), 512'(32'h00332211));
      chk("t3_err", 512'(bus.err_o), 512'(1));
      chk("t3_lat", 512'(t - pulse_t[pulse_t.size()-1]), 512'(2 * RC + 1));
      @(negedge clk);
      emit_n = B;

      // stray strobe on row 0
      do_reset();
      rand_bytes();
      spur_en = 1;
      send_frame();
      wait_out(t);
      chk("t4_res", 512'(bus.res_data_o), 512'(pack_bytes(B)));
      chk("t4_err", 512'(bus.err_o), 512'(1));
      @(negedge clk);

      // asynchronous reset while row 1 waits
      send_row(rand_row());
      send_row(rand_row());
      repeat (4) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("t5_ready", 512'(bus.row_ready_o), 512'(0));
      chk("t5_dvalid", 512'(bus.dense_valid_o), 512'(0));
      chk("t5_ddata", 512'(bus.dense_data_o), 512'(0));
      chk("t5_rvalid", 512'(bus.res_valid_o), 512'(0));
      chk("t5_rdata", 512'(bus.res_data_o), 512'(0));
      chk("t5_err", 512'(bus.err_o), 512'(0));
      repeat (2) @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
      spur_en = 0;
      rand_bytes();
      send_frame();
      wait_out(t);
      chk("t5_res", 512'(bus.res_data_o), 512'(pack_bytes(B)));
      chk("t5_err_after", 512'(bus.err_o), 512'(0));
      @(negedge clk);

      // row_valid held high across two frames
      rand_bytes();
      n0 = pulse_t.size();
      hs = 0;
      bus.row_valid_i = 1'b1;
      for (int n = 0; n < 600 && hs < 2; n++) begin
         bus.row_data_i = rand_row();
         if (bus.res_valid_o) begin
            hs++;
            chk("t6_res", 512'(bus.res_data_o), 512'(pack_bytes(B)));
         end
         @(negedge clk);
      end
      bus.row_valid_i = 1'b0;
      chk("t6_frames", 512'(hs), 512'(2));
      @(negedge clk);
      chk("t6_accepts", 512'(pulse_t.size() - n0), 512'(6));
      chk("t6_err", 512'(bus.err_o), 512'(0));

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dense_row_scheduler.md
Name: dense_row_scheduler

Overview:
- Sequences the integer dense front-end: accepts H flattened input rows (W*D bytes each) from the upstream conv/flatten stage through a valid/ready handshake.
- Issues each row to the dense datapath as a one-cycle valid pulse, then holds off for the datapath's fixed per-row accumulation window.
- Collects the B one-byte results produced during the final row and presents them as one packed vector to the next layer.
- Restarts for the next frame.

Parameters:
H, 3, rows per frame (dense input height)
W, 3, columns per row
D, 12, depth of previous layer
B, 64, dense output count (bias entries)
DATA_WIDTH, 8, bits per activation/result
ROW_CYCLES, 2*B+2, cycles the datapath needs per issued row before the next issue

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
row_valid_i  in  1  upstream row available
row_ready_o  out  1  scheduler can accept a row
row_data_i  in  W*D*DATA_WIDTH  upstream row
dense_valid_o  out  1  one-cycle row issue to datapath
dense_data_o  out  W*D*DATA_WIDTH  row held for datapath
dense_res_valid_i  in  1  datapath result strobe (one per output b, in order b=0..B-1)
dense_res_i  in  DATA_WIDTH  datapath result byte
res_valid_o  out  1  packed frame result valid
res_data_o  out  B*DATA_WIDTH  byte k at [k*DATA_WIDTH +: DATA_WIDTH]
res_ready_i  in  1  downstream accepts result
err_o  out  1  sticky protocol error

Behaviour:
- Reset: one clock, asynchronous active-low reset on rstn; all registers clear immediately on rstn low, independent of clk. On reset: state=S_LOAD, row_ready_o=0 during reset then 1, dense_valid_o=0, dense_data_o=0, res_valid_o=0, res_data_o=0, err_o=0, h_cnt=0, wait_cnt=0, res_idx=0.
- Reset mid-operation: discards the partial frame and any captured bytes; datapath is reset from the same rstn.
- States:
  - S_LOAD: row_ready_o=1. On row_valid_i, latch row_data_i into dense_data_o, go S_ISSUE.
  - S_ISSUE: dense_valid_o=1 for exactly this cycle; wait_cnt<=ROW_CYCLES-1; go S_WAIT.
  - S_WAIT: row_ready_o=0; dense_data_o held stable; wait_cnt decrements each cycle. At wait_cnt==0:
    - h_cnt<H-1: h_cnt++, go S_LOAD.
    - h_cnt==H-1: go S_COLLECT with wait_cnt<=ROW_CYCLES-1.
  - S_COLLECT: go S_OUT when res_idx==B. Otherwise wait_cnt decrements; at 0, set err_o, go S_OUT. Missing bytes keep reset value 0.
  - S_OUT: res_valid_o=1; res_data_o stable until res_valid_o&res_ready_i. On that handshake: res_valid_o<=0, h_cnt<=0, res_idx<=0, res_data_o unchanged, go S_LOAD.
- Result capture:
  - Accepted only while h_cnt==H-1 in S_WAIT or S_COLLECT, and while res_idx<B.
  - Each accepted strobe writes dense_res_i into byte res_idx, then res_idx++.
  - Strobe in any other state/row, or with res_idx==B: byte dropped, err_o set.
  - Frame start (handshake in S_OUT) clears res_idx only; bytes are overwritten during the next frame.
- Latency: row accepted at edge N gives dense_valid_o high in cycle N+1. Minimum frame time is H*(ROW_CYCLES+2) cycles plus collect and out.
- Backpressure: a held row_valid_i with row_ready_o=0 is not consumed; row_data_i sampled only on valid&ready.
- res_ready_i low stalls in S_OUT indefinitely; upstream rows are not accepted during the stall.
- err_o clears only on reset.
- Width rules: h_cnt clogb2(H) bits, res_idx clogb2(B+1) bits, wait_cnt clogb2(ROW_CYCLES) bits; no arithmetic on data bytes.

Test Plan:
- B=4, H=3, ROW_CYCLES=10, datapath model emitting results 0x11,0x22,0x33,0x44 during row 2 -> exactly 3 single-cycle dense_valid_o pulses 12 cycles apart; res_valid_o with res_data_o=0x44332211; err_o=0.
- res_ready_i held low 20 cycles after res_valid_o -> res_data_o stable; row_ready_o=0 throughout; release gives one handshake, then row_ready_o=1 next cycle.
- Model emits only 3 of 4 results -> timeout after 10 cycles in S_COLLECT; res_data_o=0x00332211; err_o=1.
- Spurious dense_res_i=0x7F while h_cnt=0 -> byte ignored; err_o=1; final packed result unaffected.
- rstn asserted asynchronously mid-S_WAIT of row 1 -> all outputs 0 before next clk edge. After release, full frame produces correct result with h_cnt restarted at 0.
- row_valid_i held high continuously for 2 frames -> rows accepted only in S_LOAD (6 accepts total); both frames return correct packed results.
